// File: rtl/seq_mult_64x64.sv
// Purpose : iterative 64x64 unsigned multiplier, full 128-bit product from four 32x32 partial products.
// Latency : fixed; finish_o pulses in the 6th cycle after the start cycle (NUM_MULS MUL cycles + ACC).
// Backpr. : none; start_i is sampled only while idle, and a start during busy_o is dropped, not queued.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset; aborts any operation in flight
//   start_i      request, accepted only in IDLE
//   busy_o       high while a multiplication is in flight
//   finish_o     one-cycle pulse, outdata_r_o is valid
//   indata_a_i   operand a (unsigned), latched at start acceptance
//   indata_b_i   operand b (unsigned), latched at start acceptance
//   outdata_r_o  product a*b, held until the next ACC cycle overwrites it
//
// Optional macro: SEQ_MULT_ASSERT_EN compiles in simulation-only protocol checks.
// The datapath is identical with or without it.

module seq_mult_64x64 #(
  parameter int NUM_MULS = 4,
  parameter int DATA_W   = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic                busy_o,
  output logic                finish_o,
  input  logic [DATA_W-1:0]   indata_a_i,
  input  logic [DATA_W-1:0]   indata_b_i,
  output logic [2*DATA_W-1:0] outdata_r_o
);

  localparam int HALF_W = DATA_W / 2;
  localparam int RES_W  = 2 * DATA_W;
  localparam int CNT_W  = $clog2(NUM_MULS);
  localparam int SH_W   = $clog2(RES_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [RES_W-1:0]  acc;

  logic [HALF_W-1:0] pp_a;
  logic [HALF_W-1:0] pp_b;
  logic [SH_W-1:0]   pp_sh;
  logic [DATA_W-1:0] pp_prod;
  logic [RES_W-1:0]  pp_ext;

  // Half-operand and offset selection for the partial product of this cycle.
  // Order: a0*b0 @0, a0*b1 @32, a1*b0 @32, a1*b1 @64.
  always_comb begin
    pp_a  = a_q[HALF_W-1:0];
    pp_b  = b_q[HALF_W-1:0];
    pp_sh = '0;
    case (cnt)
      2'd1: begin
        pp_a  = a_q[HALF_W-1:0];
        pp_b  = b_q[DATA_W-1:HALF_W];
        pp_sh = SH_W'(HALF_W);
      end
      2'd2: begin
        pp_a  = a_q[DATA_W-1:HALF_W];
        pp_b  = b_q[HALF_W-1:0];
        pp_sh = SH_W'(HALF_W);
      end
      2'd3: begin
        pp_a  = a_q[DATA_W-1:HALF_W];
        pp_b  = b_q[DATA_W-1:HALF_W];
        pp_sh = SH_W'(DATA_W);
      end
      default: begin
        pp_a  = a_q[HALF_W-1:0];
        pp_b  = b_q[HALF_W-1:0];
        pp_sh = '0;
      end
    endcase
  end

  // Zero-extend before multiplying so the full 64-bit partial product is kept.
  assign pp_prod = {{HALF_W{1'b0}}, pp_a} * {{HALF_W{1'b0}}, pp_b};
  assign pp_ext  = {{DATA_W{1'b0}}, pp_prod} << pp_sh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      busy_o      <= 1'b0;
      finish_o    <= 1'b0;
      outdata_r_o <= '0;
    end else begin
      finish_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_q    <= indata_a_i;
            b_q    <= indata_b_i;
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          // Sum of all four terms is a*b < 2^128, so the 128-bit add never wraps.
          acc <= acc + pp_ext;
          if (cnt == CNT_W'(NUM_MULS - 1)) begin
            state <= S_ACC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ACC: begin
          outdata_r_o <= acc;
          finish_o    <= 1'b1;
          busy_o      <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_MULT_ASSERT_EN
  a_finish_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    finish_o |=> !finish_o);

  a_finish_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    finish_o |-> !busy_o);

  a_operands_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (start_i && !busy_o) |-> !$isunknown({indata_a_i, indata_b_i}));

  always @(posedge clk_i) begin
    if (rst_ni && start_i && busy_o) begin
      $warning("seq_mult_64x64: start_i while busy_o, request ignored");
    end
  end
`endif

endmodule

// File: tb/tb_seq_mult_64x64.sv
// Directed bench for seq_mult_64x64: reset state, products, operand isolation,
// back-to-back starts, held start, and mid-operation reset.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.

module tb_seq_mult_64x64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         finish;
  logic [63:0]  a = '0;
  logic [63:0]  b = '0;
  logic [127:0] r;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  seq_mult_64x64 dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .finish_o    (finish),
    .indata_a_i  (a),
    .indata_b_i  (b),
    .outdata_r_o (r)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start pulse, five busy cycles, then the finish cycle.
  // prev is the result that must stay on outdata_r_o while busy.
  task automatic run_op(input string tag, input logic [63:0] op_a, input logic [63:0] op_b,
                        input logic [127:0] exp, input logic [127:0] prev, input bit scramble);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check({tag, " busy"},   busy,   1'b1);
      check({tag, " finish"}, finish, 1'b0);
      check({tag, " held"},   r,      prev);
      if (scramble) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
    end
    tick();
    check({tag, " fin"},     finish, 1'b1);
    check({tag, " idle"},    busy,   1'b0);
    check({tag, " product"}, r,      exp);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst busy",   busy,   1'b0);
    check("rst finish", finish, 1'b0);
    check("rst result", r,      128'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst busy",   busy,   1'b0);
    check("post-rst result", r,      128'h0);

    // 3 * 5
    run_op("mul3x5", 64'd3, 64'd5, 128'd15, 128'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold result", r,      128'd15);
      check("hold finish", finish, 1'b0);
      check("hold busy",   busy,   1'b0);
    end

    // All-ones operands: (2^64-1)^2 = 2^128 - 2^65 + 1
    run_op("ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 128'd15, 1'b0);

    // 2^32 * b = b << 32, inputs scrambled while busy
    run_op("shift32", 64'h0000_0001_0000_0000, 64'h1234_5678_9ABC_DEF0,
           128'h0000_0000_1234_5678_9ABC_DEF0_0000_0000,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1);

    // Back-to-back: second start issued in the first finish cycle
    run_op("b2b first", 64'd2, 64'd7, 128'd14,
           128'h0000_0000_1234_5678_9ABC_DEF0_0000_0000, 1'b0);
    run_op("b2b second", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
           128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'd14, 1'b0);

    // Held start: accepted every 6 edges, finish on edges 5, 11, 17
    a     = 64'd9;
    b     = 64'd11;
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      check("held-start finish", finish, ((i % 6) == 5) ? 1'b1 : 1'b0);
      if ((i % 6) == 5) check("held-start product", r, 128'd99);
    end
    start = 1'b0;

    // Reset in the third cycle of an operation
    a     = 64'd5;
    b     = 64'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort busy",   busy,   1'b0);
    check("abort finish", finish, 1'b0);
    check("abort result", r,      128'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("no finish after abort", finish, 1'b0);
      check("idle after abort",      busy,   1'b0);
    end

    // (2^32+1)^2 = 2^64 + 2^33 + 1
    run_op("after reset", 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
           128'h0000_0000_0000_0001_0000_0002_0000_0001, 128'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
